// File: rtl/fir_ctrl_pkg.sv
// Shared types and width helpers for the FIR coefficient controller.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWAP  = 2'd2,
    FLUSH = 2'd3
  } fir_ctrl_state_t;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: one active bank drives the filter,
// the other (shadow) bank absorbs a new set without disturbing it.
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS   = 60,
  parameter int COEF_WIDTH = 16,
  parameter int IDX_W      = cnt_width(NUM_TAPS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [COEF_WIDTH-1:0]          wr_data,
  input  logic                           sel,
  input  logic                           swap,
  output logic [NUM_TAPS*COEF_WIDTH-1:0] coefficients
);

  logic [1:0][NUM_TAPS-1:0][COEF_WIDTH-1:0] mem;

  // Writes land in the shadow bank only; a write coinciding with the swap
  // cycle is dropped so it can never reach the bank about to go live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      mem <= '0;
    else if (wr_en && !swap)
      mem[~sel][wr_idx] <= wr_data;
  end

  // Active bank flattened so tap i sits at [i*COEF_WIDTH +: COEF_WIDTH].
  always_comb begin
    coefficients = mem[sel];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient controller: streams a new set into the shadow bank, swaps
// atomically on a well-formed load, then masks the filter output while the
// pipeline drains products formed with the old set.
module fir_coef_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS     = 60,
  parameter int COEF_WIDTH   = 16,
  parameter int FLUSH_CYCLES = NUM_TAPS + 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [COEF_WIDTH-1:0]          cfg_data,
  input  logic                           cfg_last,
  input  logic                           cfg_abort,
  output logic [NUM_TAPS*COEF_WIDTH-1:0] coefficients,
  output logic                           bank_sel,
  output logic                           busy,
  output logic                           swap_done,
  output logic                           load_error,
  output logic                           out_valid
);

  localparam int CW = cnt_width(NUM_TAPS);
  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_TAPS - 1);
  localparam logic [FW-1:0] FLUSH_TOP = FW'(FLUSH_CYCLES - 1);

  fir_ctrl_state_t state, state_nxt;
  logic [CW-1:0]   count;
  logic [FW-1:0]   flush_cnt;
  logic            wr_en;
  logic            err_nxt;

  assign cfg_ready = (state == LOAD);

  // Next-state decode; abort pre-empts any beat presented with it.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE:  if (cfg_start) state_nxt = LOAD;
      LOAD: begin
        if (cfg_abort) begin
          state_nxt = IDLE;
        end else if (cfg_valid) begin
          wr_en = 1'b1;
          if (count == LAST_IDX) begin
            state_nxt = cfg_last ? SWAP : IDLE;
            err_nxt   = !cfg_last;
          end else if (cfg_last) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      SWAP:  state_nxt = FLUSH;
      FLUSH: if (flush_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset lands in FLUSH so the filter warms up masked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FLUSH;
    else          state <= state_nxt;
  end

  // Beat counter: cleared on start, advanced per accepted beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      count <= '0;
    else if (state == IDLE && cfg_start) count <= '0;
    else if (wr_en)                    count <= count + 1'b1;
  end

  // Flush counter: reloaded by the swap, counts down through FLUSH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              flush_cnt <= FLUSH_TOP;
    else if (state == SWAP)                    flush_cnt <= FLUSH_TOP;
    else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel   <= 1'b0;
      busy       <= 1'b1;
      swap_done  <= 1'b0;
      load_error <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (state == SWAP) bank_sel <= ~bank_sel;
      busy       <= (state_nxt != IDLE);
      swap_done  <= (state_nxt == SWAP);
      load_error <= err_nxt;
      out_valid  <= (state_nxt == IDLE) || (state_nxt == LOAD);
    end
  end

  fir_coef_bank #(
    .NUM_TAPS  (NUM_TAPS),
    .COEF_WIDTH(COEF_WIDTH),
    .IDX_W     (CW)
  ) u_bank (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_idx      (count),
    .wr_data     (cfg_data),
    .sel         (bank_sel),
    .swap        (state == SWAP),
    .coefficients(coefficients)
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl with a transaction-level reference model.
module tb_fir_coef_ctrl;

  localparam int NT  = 60;
  localparam int W   = 16;
  localparam int FC  = NT + 3;
  localparam int BIG = 32'h7fff_ffff;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0, cfg_abort = 1'b0;
  logic [W-1:0]      cfg_data = '0;
  logic              cfg_ready, bank_sel, busy, swap_done, load_error, out_valid;
  logic [NT*W-1:0]   coefficients;

  fir_coef_ctrl #(.NUM_TAPS(NT), .COEF_WIDTH(W), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
    .coefficients(coefficients), .bank_sel(bank_sel), .busy(busy), .swap_done(swap_done),
    .load_error(load_error), .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  // Model state: two banks, active index, pending set, and event schedule.
  logic [W-1:0] m_bank [2][NT];
  logic [W-1:0] pending [NT];
  logic         m_sel;
  int cyc = 0, swap_at = -1, err_at = -1, flip_at = -1;
  int ov_lo_from = 0, ov_high_at = BIG;
  int n_cmp = 0, n_fail = 0, sw_cnt = 0, low_run = 0, last_low_run = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      logic [NT*W-1:0] exp_c;
      if (cyc == flip_at) begin
        for (int i = 0; i < NT; i++) m_bank[!m_sel][i] = pending[i];
        m_sel = !m_sel;
      end
      for (int i = 0; i < NT; i++) exp_c[i*W +: W] = m_bank[m_sel][i];
      chk("out_valid", {31'd0, out_valid},
          {31'd0, !(cyc >= ov_lo_from && cyc < ov_high_at)});
      chk("bank_sel", {31'd0, bank_sel}, {31'd0, m_sel});
      chk("swap_done", {31'd0, swap_done}, {31'd0, cyc == swap_at});
      chk("load_error", {31'd0, load_error}, {31'd0, cyc == err_at});
      n_cmp++;
      if (coefficients !== exp_c) begin
        n_fail++;
        for (int i = 0; i < NT; i++)
          if (coefficients[i*W +: W] !== exp_c[i*W +: W]) begin
            $display("FAIL coefficients tap %0d at cycle %0d: got %h expected %h",
                     i, cyc, coefficients[i*W +: W], exp_c[i*W +: W]);
            break;
          end
      end
      if (swap_done) sw_cnt++;
      if (!reset_n) low_run = 0;
      else if (!out_valid) low_run++;
      else if (low_run != 0) begin
        last_low_run = low_run;
        low_run = 0;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cfg_start = 0; cfg_valid = 0; cfg_last = 0; cfg_abort = 0; cfg_data = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NT; i++) m_bank[b][i] = '0;
    m_sel = 1'b0; swap_at = -1; err_at = -1; flip_at = -1;
    ov_lo_from = 0; ov_high_at = BIG;
    tick();
    tick();
    reset_n = 1'b1;
    ov_high_at = cyc + FC;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Start a load and present up to n beats, data = base + step*i.
  task automatic load_set(input int n, input int last_at, input int abort_at,
                          input int base, input int step);
    int k;
    bit done;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("ready_after_start", {31'd0, cfg_ready}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = W'(base + step * i);
      cfg_last  = (i == last_at);
      cfg_abort = (i == abort_at);
      k = cyc;
      if (i == abort_at) begin
        done = 1'b1;
      end else begin
        pending[i] = cfg_data;
        if (i == last_at && i == NT - 1) begin
          swap_at = k + 1; flip_at = k + 2;
          ov_lo_from = k + 1; ov_high_at = k + FC + 2;
          done = 1'b1;
        end else if (i == last_at || i == NT - 1) begin
          err_at = k + 1;
          done = 1'b1;
        end
      end
      tick();
    end
    cfg_valid = 0; cfg_last = 0; cfg_abort = 0; cfg_data = '0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    // Reset: 63 masked cycles, zero coefficients, idle handshake.
    chk("reset_ready", {31'd0, cfg_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    tick();
    chk("reset_low_run", last_low_run, 32'd63);
    chk("reset_tap0", {16'd0, coefficients[0 +: W]}, 32'd0);

    // Clean load with ramp data.
    load_set(NT, NT - 1, -1, 0, 1);
    tick();
    chk("clean_tap30", {16'd0, coefficients[30*W +: W]}, 32'h001E);
    chk("clean_bank_sel", {31'd0, bank_sel}, 32'd1);
    chk("clean_swaps", sw_cnt, 32'd1);
    wait_idle();
    tick();
    chk("clean_low_run", last_low_run, 32'd64);

    // Short set: last on beat 10.
    load_set(NT, 10, -1, 16'h0100, 1);
    chk("short_idle", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("short_bank_sel", {31'd0, bank_sel}, 32'd1);

    // Long set: no last at all.
    load_set(NT, -1, -1, 16'h0200, 1);
    chk("long_idle", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("long_no_swap", sw_cnt, 32'd1);

    // Abort with a beat on 20, then a clean 7FFF load.
    load_set(NT, -1, 20, 16'h0300, 1);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    tick(); tick();
    load_set(NT, NT - 1, -1, 16'h7FFF, 0);
    tick();
    chk("max_tap0", {16'd0, coefficients[0 +: W]}, 32'h7FFF);
    chk("max_tap59", {16'd0, coefficients[59*W +: W]}, 32'h7FFF);
    chk("max_bank_sel", {31'd0, bank_sel}, 32'd0);
    chk("max_swaps", sw_cnt, 32'd2);

    // Start during FLUSH is dropped.
    for (int i = 0; i < 5; i++) tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    for (int i = 0; i < 3; i++) tick();
    chk("flush_start_ready", {31'd0, cfg_ready}, 32'd0);
    chk("flush_start_busy_end", {31'd0, busy}, 32'd0);

    // Reset at beat 40 of a load zeroes both banks.
    load_set(40, -1, -1, 16'h0400, 1);
    do_reset();
    chk("midrst_bank_sel", {31'd0, bank_sel}, 32'd0);
    chk("midrst_tap0", {16'd0, coefficients[0 +: W]}, 32'd0);
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
